// File: rtl/pa_pkg.sv
// Shared definitions for the memory stage: instruction classes, funct3 codes, FSM states.
// Also provides the default data width used by mem_stage.
`ifndef WORD_SIZE
`define WORD_SIZE 32
`endif

package pa_pkg;

   localparam logic [1:0] CLS_ALU    = 2'b00;
   localparam logic [1:0] CLS_LOAD   = 2'b01;
   localparam logic [1:0] CLS_STORE  = 2'b10;
   localparam logic [1:0] CLS_BRANCH = 2'b11;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;
   localparam logic [2:0] F3_SB  = 3'b000;
   localparam logic [2:0] F3_SH  = 3'b001;
   localparam logic [2:0] F3_SW  = 3'b010;

   typedef enum logic [1:0] {IDLE, REQ, WAIT_RESP, OUT} state_e;

   // Halfword (LH/LHU/SH share funct3[1:0]=01) on an odd byte, or word not on a word boundary.
   function automatic logic misaligned(input logic [2:0] funct3, input logic [1:0] offset);
      return ((funct3[1:0] == 2'b01) && offset[0]) || ((funct3 == F3_LW) && (offset != 2'b00));
   endfunction

endpackage

// File: rtl/load_align.sv
// Selects the addressed byte/halfword lane of a read word and sign- or zero-extends it.
module load_align
   import pa_pkg::*;
#(
   parameter int unsigned WORD_SIZE = 32
) (
   input  logic [2:0]           funct3,
   input  logic [1:0]           offset,
   input  logic [WORD_SIZE-1:0] rdata,
   output logic [WORD_SIZE-1:0] data
);

   logic [7:0]  lane_b;
   logic [15:0] lane_h;

   always_comb begin
      lane_b = rdata[{offset, 3'b000} +: 8];
      lane_h = rdata[{offset[1], 4'b0000} +: 16];
      case (funct3)
         F3_LB:   data = {{(WORD_SIZE-8){lane_b[7]}}, lane_b};
         F3_LH:   data = {{(WORD_SIZE-16){lane_h[15]}}, lane_h};
         F3_LBU:  data = {{(WORD_SIZE-8){1'b0}}, lane_b};
         F3_LHU:  data = {{(WORD_SIZE-16){1'b0}}, lane_h};
         default: data = rdata;
      endcase
   end

endmodule

// File: rtl/mem_stage.sv
// Pipeline memory stage: passes ALU results through, issues load/store requests, formats loads.
// Optional MEM_MISALIGN_EXC_EN turns misaligned half/word accesses into writeback exceptions.
`ifndef WORD_SIZE
`define WORD_SIZE 32
`endif

module mem_stage
   import pa_pkg::*;
#(
   parameter int unsigned WORD_SIZE = `WORD_SIZE,
   parameter int unsigned ROB_ID_W  = 7
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 valid_in,
   input  logic [1:0]           instruction_type_in,
   input  logic [WORD_SIZE-1:0] pc_in,
   input  logic [2:0]           funct3_in,
   input  logic [WORD_SIZE-1:0] alu_result_in,
   input  logic [WORD_SIZE-1:0] s2_in,
   input  logic [ROB_ID_W-1:0]  rob_id_in,
   output logic                 stall_out,
   output logic                 mem_req_valid,
   input  logic                 mem_req_ready,
   output logic                 mem_req_we,
   output logic [WORD_SIZE-1:0] mem_req_addr,
   output logic [WORD_SIZE-1:0] mem_req_wdata,
   output logic [3:0]           mem_req_wstrb,
   input  logic                 mem_resp_valid,
   input  logic [WORD_SIZE-1:0] mem_resp_rdata,
   output logic                 wb_valid,
   output logic [WORD_SIZE-1:0] wb_data,
   output logic [WORD_SIZE-1:0] wb_pc,
   output logic [ROB_ID_W-1:0]  wb_rob_id,
   output logic                 wb_exc,
   input  logic                 wb_stall_in
);

   state_e               state;
   logic [2:0]           funct3_q;
   logic [1:0]           offset_q;
   logic                 is_mem;
   logic                 accept;
   logic                 mis;
   logic [WORD_SIZE-1:0] st_wdata;
   logic [3:0]           st_wstrb;
   logic [WORD_SIZE-1:0] ld_data;

   assign is_mem    = (instruction_type_in == CLS_LOAD) || (instruction_type_in == CLS_STORE);
   // A result held by downstream must not be overwritten by a new accept.
   assign accept    = (state == IDLE) && valid_in && !(wb_valid && wb_stall_in);
   assign stall_out = (state != IDLE) || (wb_valid && wb_stall_in) || (valid_in && is_mem);

`ifdef MEM_MISALIGN_EXC_EN
   logic exc_q;

   assign mis    = misaligned(funct3_in, alu_result_in[1:0]);
   assign wb_exc = exc_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         exc_q <= 1'b0;
      end else if (accept) begin
         exc_q <= is_mem && mis;
      end else if ((state == OUT) && !wb_stall_in) begin
         exc_q <= 1'b0;
      end
   end
`else
   assign mis    = 1'b0;
   assign wb_exc = 1'b0;
`endif

   always_comb begin
      st_wdata = s2_in;
      st_wstrb = 4'b1111;
      case (funct3_in)
         F3_SB: begin
            st_wdata = {(WORD_SIZE/8){s2_in[7:0]}};
            st_wstrb = 4'b0001 << alu_result_in[1:0];
         end
         F3_SH: begin
            st_wdata = {(WORD_SIZE/16){s2_in[15:0]}};
            st_wstrb = 4'b0011 << {alu_result_in[1], 1'b0};
         end
         default: ;
      endcase
   end

   load_align #(
      .WORD_SIZE(WORD_SIZE)
   ) u_load_align (
      .funct3(funct3_q),
      .offset(offset_q),
      .rdata (mem_resp_rdata),
      .data  (ld_data)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state         <= IDLE;
         funct3_q      <= '0;
         offset_q      <= '0;
         mem_req_valid <= 1'b0;
         mem_req_we    <= 1'b0;
         mem_req_addr  <= '0;
         mem_req_wdata <= '0;
         mem_req_wstrb <= '0;
         wb_valid      <= 1'b0;
         wb_data       <= '0;
         wb_pc         <= '0;
         wb_rob_id     <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (accept) begin
                  wb_pc     <= pc_in;
                  wb_rob_id <= rob_id_in;
                  funct3_q  <= funct3_in;
                  offset_q  <= alu_result_in[1:0];
                  if (!is_mem || mis) begin
                     state    <= is_mem ? OUT : IDLE;
                     wb_valid <= 1'b1;
                     wb_data  <= alu_result_in;
                  end else begin
                     state         <= REQ;
                     wb_valid      <= 1'b0;
                     mem_req_valid <= 1'b1;
                     mem_req_we    <= (instruction_type_in == CLS_STORE);
                     mem_req_addr  <= {alu_result_in[WORD_SIZE-1:2], 2'b00};
                     mem_req_wdata <= st_wdata;
                     mem_req_wstrb <= (instruction_type_in == CLS_STORE) ? st_wstrb : 4'b0000;
                  end
               end else if (!wb_stall_in) begin
                  wb_valid <= 1'b0;
               end
            end
            REQ: begin
               if (mem_req_ready) begin
                  mem_req_valid <= 1'b0;
                  if (mem_req_we) begin
                     state    <= OUT;
                     wb_valid <= 1'b1;
                     wb_data  <= '0;
                  end else begin
                     state <= WAIT_RESP;
                  end
               end
            end
            WAIT_RESP: begin
               if (mem_resp_valid) begin
                  state    <= OUT;
                  wb_valid <= 1'b1;
                  wb_data  <= ld_data;
               end
            end
            OUT: begin
               if (!wb_stall_in) begin
                  state    <= IDLE;
                  wb_valid <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage; misalignment checks follow MEM_MISALIGN_EXC_EN.
module tb_mem_stage;
   import pa_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        valid_in;
   logic [1:0]  instruction_type_in;
   logic [31:0] pc_in;
   logic [2:0]  funct3_in;
   logic [31:0] alu_result_in;
   logic [31:0] s2_in;
   logic [6:0]  rob_id_in;
   logic        stall_out;
   logic        mem_req_valid;
   logic        mem_req_ready;
   logic        mem_req_we;
   logic [31:0] mem_req_addr;
   logic [31:0] mem_req_wdata;
   logic [3:0]  mem_req_wstrb;
   logic        mem_resp_valid;
   logic [31:0] mem_resp_rdata;
   logic        wb_valid;
   logic [31:0] wb_data;
   logic [31:0] wb_pc;
   logic [6:0]  wb_rob_id;
   logic        wb_exc;
   logic        wb_stall_in;

   int checks = 0;
   int errors = 0;

   mem_stage dut (
      .clk                (clk),
      .rst_n              (rst_n),
      .valid_in           (valid_in),
      .instruction_type_in(instruction_type_in),
      .pc_in              (pc_in),
      .funct3_in          (funct3_in),
      .alu_result_in      (alu_result_in),
      .s2_in              (s2_in),
      .rob_id_in          (rob_id_in),
      .stall_out          (stall_out),
      .mem_req_valid      (mem_req_valid),
      .mem_req_ready      (mem_req_ready),
      .mem_req_we         (mem_req_we),
      .mem_req_addr       (mem_req_addr),
      .mem_req_wdata      (mem_req_wdata),
      .mem_req_wstrb      (mem_req_wstrb),
      .mem_resp_valid     (mem_resp_valid),
      .mem_resp_rdata     (mem_resp_rdata),
      .wb_valid           (wb_valid),
      .wb_data            (wb_data),
      .wb_pc              (wb_pc),
      .wb_rob_id          (wb_rob_id),
      .wb_exc             (wb_exc),
      .wb_stall_in        (wb_stall_in)
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [1:0] cls, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] s2, input logic [31:0] pc, input logic [6:0] rob);
      valid_in            = 1'b1;
      instruction_type_in = cls;
      funct3_in           = f3;
      alu_result_in       = addr;
      s2_in               = s2;
      pc_in               = pc;
      rob_id_in           = rob;
   endtask

   task automatic test_reset;
      rst_n = 1'b0; valid_in = 1'b0; instruction_type_in = CLS_ALU; pc_in = '0; funct3_in = '0;
      alu_result_in = '0; s2_in = '0; rob_id_in = '0; mem_req_ready = 1'b0;
      mem_resp_valid = 1'b0; mem_resp_rdata = '0; wb_stall_in = 1'b0;
      tick; tick;
      checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL rst_wb_valid: got %b want 0", wb_valid); end
      checks++; if (mem_req_valid !== 1'b0) begin errors++; $display("FAIL rst_req_valid: got %b want 0", mem_req_valid); end
      checks++; if (wb_exc !== 1'b0) begin errors++; $display("FAIL rst_wb_exc: got %b want 0", wb_exc); end
      checks++; if (wb_data !== 32'h0) begin errors++; $display("FAIL rst_wb_data: got %h want 0", wb_data); end
      checks++; if (mem_req_addr !== 32'h0) begin errors++; $display("FAIL rst_req_addr: got %h want 0", mem_req_addr); end
      checks++; if (stall_out !== 1'b0) begin errors++; $display("FAIL rst_stall: got %b want 0", stall_out); end
      rst_n = 1'b1;
      tick;
   endtask

   task automatic test_alu;
      issue(CLS_ALU, 3'b000, 32'h1234, 32'h0, 32'h40, 7'd5);
      #1;
      checks++; if (stall_out !== 1'b0) begin errors++; $display("FAIL alu_stall_acc: got %b want 0", stall_out); end
      tick;
      valid_in = 1'b0;
      #1;
      checks++; if (wb_valid !== 1'b1) begin errors++; $display("FAIL alu_valid: got %b want 1", wb_valid); end
      checks++; if (wb_data !== 32'h1234) begin errors++; $display("FAIL alu_data: got %h want 00001234", wb_data); end
      checks++; if (wb_pc !== 32'h40) begin errors++; $display("FAIL alu_pc: got %h want 00000040", wb_pc); end
      checks++; if (wb_rob_id !== 7'd5) begin errors++; $display("FAIL alu_rob: got %0d want 5", wb_rob_id); end
      checks++; if (stall_out !== 1'b0) begin errors++; $display("FAIL alu_stall_wb: got %b want 0", stall_out); end
      checks++; if (mem_req_valid !== 1'b0) begin errors++; $display("FAIL alu_no_req: got %b want 0", mem_req_valid); end
      tick;
      checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL alu_valid_drop: got %b want 0", wb_valid); end
   endtask

   task automatic test_back_to_back;
      issue(CLS_ALU, 3'b000, 32'h11, 32'h0, 32'h100, 7'd1);
      tick;
      issue(CLS_ALU, 3'b000, 32'h22, 32'h0, 32'h104, 7'd2);
      wb_stall_in = 1'b1;
      #1;
      checks++; if (stall_out !== 1'b1) begin errors++; $display("FAIL b2b_stall_held: got %b want 1", stall_out); end
      tick;
      checks++; if (wb_data !== 32'h11) begin errors++; $display("FAIL b2b_hold_data: got %h want 00000011", wb_data); end
      checks++; if (wb_rob_id !== 7'd1) begin errors++; $display("FAIL b2b_hold_rob: got %0d want 1", wb_rob_id); end
      wb_stall_in = 1'b0;
      #1;
      checks++; if (stall_out !== 1'b0) begin errors++; $display("FAIL b2b_stall_rel: got %b want 0", stall_out); end
      tick;
      checks++; if (wb_data !== 32'h22) begin errors++; $display("FAIL b2b_data2: got %h want 00000022", wb_data); end
      issue(CLS_BRANCH, 3'b000, 32'h33, 32'h0, 32'h108, 7'd3);
      tick;
      valid_in = 1'b0;
      checks++; if (wb_data !== 32'h33 || wb_valid !== 1'b1) begin errors++; $display("FAIL b2b_branch: got %b/%h want 1/00000033", wb_valid, wb_data); end
      tick;
      checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL b2b_idle: got %b want 0", wb_valid); end
   endtask

   task automatic test_load_byte;
      issue(CLS_LOAD, F3_LB, 32'h103, 32'h0, 32'h80, 7'd9);
      #1;
      checks++; if (stall_out !== 1'b1) begin errors++; $display("FAIL lb_stall_acc: got %b want 1", stall_out); end
      tick;
      valid_in = 1'b0;
      checks++; if (mem_req_valid !== 1'b1) begin errors++; $display("FAIL lb_req_valid: got %b want 1", mem_req_valid); end
      checks++; if (mem_req_we !== 1'b0) begin errors++; $display("FAIL lb_req_we: got %b want 0", mem_req_we); end
      for (int i = 0; i < 2; i++) begin
         tick;
         checks++; if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h100) begin errors++; $display("FAIL lb_req_hold: got %b/%h want 1/00000100", mem_req_valid, mem_req_addr); end
      end
      mem_req_ready = 1'b1;
      tick;
      mem_req_ready = 1'b0;
      checks++; if (mem_req_valid !== 1'b0 || wb_valid !== 1'b0) begin errors++; $display("FAIL lb_wait: got req %b wb %b want 0/0", mem_req_valid, wb_valid); end
      mem_resp_valid = 1'b1;
      mem_resp_rdata = 32'h80AABBCC;
      tick;
      mem_resp_valid = 1'b0;
      checks++; if (wb_valid !== 1'b1 || wb_data !== 32'hFFFFFF80) begin errors++; $display("FAIL lb_data: got %b/%h want 1/ffffff80", wb_valid, wb_data); end
      checks++; if (wb_pc !== 32'h80 || wb_rob_id !== 7'd9) begin errors++; $display("FAIL lb_tag: got %h/%0d want 00000080/9", wb_pc, wb_rob_id); end
      tick;
      checks++; if (wb_valid !== 1'b0 || stall_out !== 1'b0) begin errors++; $display("FAIL lb_done: got %b/%b want 0/0", wb_valid, stall_out); end
   endtask

   task automatic test_store;
      logic [2:0]  f3   [3] = '{F3_SH, F3_SB, F3_SW};
      logic [31:0] addr [3] = '{32'h102, 32'h101, 32'h200};
      logic [31:0] s2   [3] = '{32'h0000BEEF, 32'h12345678, 32'hDEADBEEF};
      logic [31:0] eaddr[3] = '{32'h100, 32'h100, 32'h200};
      logic [3:0]  estrb[3] = '{4'b1100, 4'b0010, 4'b1111};
      logic [31:0] edata[3] = '{32'hBEEFBEEF, 32'h78787878, 32'hDEADBEEF};
      for (int i = 0; i < 3; i++) begin
         issue(CLS_STORE, f3[i], addr[i], s2[i], 32'h200 + 32'(i), 7'(20 + i));
         tick;
         valid_in = 1'b0;
         checks++; if (mem_req_valid !== 1'b1 || mem_req_we !== 1'b1) begin errors++; $display("FAIL st%0d_req: got %b/%b want 1/1", i, mem_req_valid, mem_req_we); end
         checks++; if (mem_req_addr !== eaddr[i]) begin errors++; $display("FAIL st%0d_addr: got %h want %h", i, mem_req_addr, eaddr[i]); end
         checks++; if (mem_req_wstrb !== estrb[i]) begin errors++; $display("FAIL st%0d_wstrb: got %b want %b", i, mem_req_wstrb, estrb[i]); end
         checks++; if (mem_req_wdata !== edata[i]) begin errors++; $display("FAIL st%0d_wdata: got %h want %h", i, mem_req_wdata, edata[i]); end
         mem_req_ready = 1'b1;
         tick;
         mem_req_ready = 1'b0;
         checks++; if (mem_req_valid !== 1'b0 || wb_valid !== 1'b1 || wb_data !== 32'h0) begin errors++; $display("FAIL st%0d_wb: got req %b wb %b data %h want 0/1/0", i, mem_req_valid, wb_valid, wb_data); end
         tick;
         checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL st%0d_done: got %b want 0", i, wb_valid); end
      end
   endtask

   task automatic test_load_formats;
      logic [2:0]  f3   [5] = '{F3_LH, F3_LBU, F3_LB, F3_LW, 3'b111};
      logic [31:0] addr [5] = '{32'h202, 32'h101, 32'h100, 32'h204, 32'h208};
      logic [31:0] rdata[5] = '{32'h80010000, 32'h1234F078, 32'h0000007F, 32'hCAFEBABE, 32'h13572468};
      logic [31:0] exp  [5] = '{32'hFFFF8001, 32'h000000F0, 32'h0000007F, 32'hCAFEBABE, 32'h13572468};
      for (int i = 0; i < 5; i++) begin
         issue(CLS_LOAD, f3[i], addr[i], 32'h0, 32'h300, 7'd30);
         tick;
         valid_in = 1'b0;
         mem_req_ready = 1'b1;
         tick;
         mem_req_ready = 1'b0;
         mem_resp_valid = 1'b1;
         mem_resp_rdata = rdata[i];
         tick;
         mem_resp_valid = 1'b0;
         checks++; if (wb_valid !== 1'b1 || wb_data !== exp[i]) begin errors++; $display("FAIL ldfmt%0d: got %b/%h want 1/%h", i, wb_valid, wb_data, exp[i]); end
         tick;
      end
   endtask

   task automatic test_load_stall;
      issue(CLS_LOAD, F3_LHU, 32'h202, 32'h0, 32'h400, 7'd44);
      tick;
      valid_in = 1'b0;
      mem_req_ready = 1'b1;
      tick;
      mem_req_ready = 1'b0;
      mem_resp_valid = 1'b1;
      mem_resp_rdata = 32'hCAFE1234;
      wb_stall_in = 1'b1;
      tick;
      mem_resp_valid = 1'b0;
      mem_resp_rdata = 32'h0;
      for (int i = 0; i < 3; i++) begin
         checks++; if (wb_valid !== 1'b1 || wb_data !== 32'h0000CAFE) begin errors++; $display("FAIL lhu_hold%0d: got %b/%h want 1/0000cafe", i, wb_valid, wb_data); end
         checks++; if (wb_pc !== 32'h400 || wb_rob_id !== 7'd44 || stall_out !== 1'b1) begin errors++; $display("FAIL lhu_tag%0d: got %h/%0d/%b want 00000400/44/1", i, wb_pc, wb_rob_id, stall_out); end
         if (i < 2) tick;
      end
      wb_stall_in = 1'b0;
      tick;
      checks++; if (wb_valid !== 1'b0 || stall_out !== 1'b0) begin errors++; $display("FAIL lhu_release: got %b/%b want 0/0", wb_valid, stall_out); end
   endtask

   task automatic test_ignored_resp;
      mem_resp_valid = 1'b1;
      mem_resp_rdata = 32'h55555555;
      tick;
      mem_resp_valid = 1'b0;
      checks++; if (wb_valid !== 1'b0 || stall_out !== 1'b0) begin errors++; $display("FAIL idle_resp: got %b/%b want 0/0", wb_valid, stall_out); end
   endtask

   task automatic test_reset_mid;
      issue(CLS_LOAD, F3_LW, 32'h300, 32'h0, 32'h500, 7'd50);
      tick;
      valid_in = 1'b0;
      mem_req_ready = 1'b1;
      tick;
      mem_req_ready = 1'b0;
      checks++; if (mem_req_valid !== 1'b0 || stall_out !== 1'b1) begin errors++; $display("FAIL rmid_wait: got %b/%b want 0/1", mem_req_valid, stall_out); end
      rst_n = 1'b0;
      tick;
      rst_n = 1'b1;
      #1;
      checks++; if (stall_out !== 1'b0 || wb_valid !== 1'b0) begin errors++; $display("FAIL rmid_idle: got %b/%b want 0/0", stall_out, wb_valid); end
      tick;
      mem_resp_valid = 1'b1;
      mem_resp_rdata = 32'hA5A5A5A5;
      tick;
      mem_resp_valid = 1'b0;
      checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL rmid_drop: got %b want 0", wb_valid); end
      tick;
      checks++; if (wb_valid !== 1'b0 || stall_out !== 1'b0) begin errors++; $display("FAIL rmid_after: got %b/%b want 0/0", wb_valid, stall_out); end
   endtask

   task automatic test_misalign;
      issue(CLS_LOAD, F3_LW, 32'h101, 32'h0, 32'h600, 7'd3);
      tick;
      valid_in = 1'b0;
`ifdef MEM_MISALIGN_EXC_EN
      checks++; if (mem_req_valid !== 1'b0) begin errors++; $display("FAIL mis_no_req: got %b want 0", mem_req_valid); end
      checks++; if (wb_valid !== 1'b1 || wb_exc !== 1'b1) begin errors++; $display("FAIL mis_exc: got %b/%b want 1/1", wb_valid, wb_exc); end
      checks++; if (wb_data !== 32'h101) begin errors++; $display("FAIL mis_data: got %h want 00000101", wb_data); end
      tick;
      checks++; if (wb_valid !== 1'b0 || wb_exc !== 1'b0) begin errors++; $display("FAIL mis_done: got %b/%b want 0/0", wb_valid, wb_exc); end
`else
      checks++; if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h100) begin errors++; $display("FAIL mis_req: got %b/%h want 1/00000100", mem_req_valid, mem_req_addr); end
      mem_req_ready = 1'b1;
      tick;
      mem_req_ready = 1'b0;
      mem_resp_valid = 1'b1;
      mem_resp_rdata = 32'h11223344;
      tick;
      mem_resp_valid = 1'b0;
      checks++; if (wb_valid !== 1'b1 || wb_data !== 32'h11223344) begin errors++; $display("FAIL mis_data: got %b/%h want 1/11223344", wb_valid, wb_data); end
      checks++; if (wb_exc !== 1'b0) begin errors++; $display("FAIL mis_exc: got %b want 0", wb_exc); end
      tick;
`endif
   endtask

   initial begin
      test_reset;
      test_alu;
      test_back_to_back;
      test_load_byte;
      test_store;
      test_load_formats;
      test_load_stall;
      test_ignored_resp;
      test_reset_mid;
      test_misalign;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
